// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display slice.
//   state_t      : conversion sequencer states
//   SEG_*        : 7-segment patterns, bit order {g,f,e,d,c,b,a}, active-high
//   seg_encode   : BCD digit -> segment pattern (non-digit codes blank)
//   clamp_score  : saturate a binary score at MAX_SCORE
package score_display_pkg;

  localparam int unsigned SCORE_W   = 7;
  localparam int unsigned MAX_SCORE = 99;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV_CURR,
    S_CONV_HIGH,
    S_STORE
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] s);
    return (s > SCORE_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : s;
  endfunction

endpackage

// File: rtl/score_display_bcd_conv.sv
// Iterative double-dabble converter, 7-bit binary (0..99) -> two BCD digits.
//   clk, rst : clock, synchronous active-high reset
//   start    : load bin and begin converting (restarts any conversion in flight)
//   bin      : binary input, must already be clamped to 0..99
//   done     : one-cycle pulse once bcd holds the result
//   bcd      : {tens, ones}
module bcd_conv
  import score_display_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic               done,
  output logic [7:0]         bcd
);

  // {tens, ones, binary remainder}
  logic [14:0] sr_q;
  logic [14:0] adj;
  logic [2:0]  cnt_q;
  logic        run_q;

  always_comb begin
    adj = sr_q;
    if (adj[10:7] >= 4'd5)
      adj[10:7] = adj[10:7] + 4'd3;
    if (adj[14:11] >= 4'd5)
      adj[14:11] = adj[14:11] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sr_q  <= {8'h00, bin};
        cnt_q <= '0;
        run_q <= 1'b1;
      end else if (run_q) begin
        sr_q  <= adj << 1;
        cnt_q <= cnt_q + 3'd1;
        if (cnt_q == 3'd6) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  assign bcd = sr_q[14:7];

endmodule

// File: rtl/score_display.sv
// Converts current and high score to BCD and scans them onto a 4-digit
// multiplexed 7-segment display (digits 1:0 current, 3:2 high).
//   clk, rst        : clock, synchronous active-high reset
//   currScore       : binary current score (clamped to 99)
//   highScore       : binary high score (clamped to 99)
//   isGameComplete  : game-over flag, used only with GAME_OVER_BLINK_EN
//   seg             : segments {g,f,e,d,c,b,a}, active-high
//   an              : one-hot digit enable, bit0 = current-score ones
//   currBcd/highBcd : displayed BCD values, updated together
//   busy            : conversion in progress
// Optional build macro GAME_OVER_BLINK_EN: blink the whole display while
// isGameComplete is high.
module score_display
  import score_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned BLINK_DIV   = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] currScore,
  input  logic [SCORE_W-1:0] highScore,
  input  logic               isGameComplete,
  output logic [6:0]         seg,
  output logic [3:0]         an,
  output logic [7:0]         currBcd,
  output logic [7:0]         highBcd,
  output logic               busy
);

  localparam int unsigned     RW       = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0]   REF_LAST = RW'(REFRESH_DIV - 1);

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] curr_sh_q, high_sh_q;
  logic [7:0]         curr_hold_q;
  logic               changed;
  logic               capture;
  logic               conv_start;
  logic [SCORE_W-1:0] conv_bin;
  logic               conv_done;
  logic [7:0]         conv_bcd;

  bcd_conv u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (conv_bin),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign changed = (currScore != curr_sh_q) || (highScore != high_sh_q);

  // ---------------- sequencer ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (changed)   state_d = S_CONV_CURR;
      S_CONV_CURR: if (conv_done) state_d = S_CONV_HIGH;
      S_CONV_HIGH: if (conv_done) state_d = S_STORE;
      S_STORE:                    state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    capture    = 1'b0;
    conv_start = 1'b0;
    conv_bin   = clamp_score(currScore);
    case (state_q)
      S_IDLE: begin
        if (changed) begin
          capture    = 1'b1;
          conv_start = 1'b1;
        end
      end
      S_CONV_CURR: begin
        conv_bin = clamp_score(high_sh_q);
        if (conv_done) conv_start = 1'b1;
      end
      default: ;
    endcase
  end

  // Both results are written on the edge into STORE, so they are valid
  // together during STORE and never torn.
  always_ff @(posedge clk) begin
    if (rst) begin
      curr_sh_q   <= '0;
      high_sh_q   <= '0;
      curr_hold_q <= '0;
      currBcd     <= '0;
      highBcd     <= '0;
      busy        <= 1'b0;
    end else begin
      busy <= (state_d != S_IDLE);
      if (capture) begin
        curr_sh_q <= currScore;
        high_sh_q <= highScore;
      end
      if (state_q == S_CONV_CURR && conv_done)
        curr_hold_q <= conv_bcd;
      if (state_q == S_CONV_HIGH && conv_done) begin
        currBcd <= curr_hold_q;
        highBcd <= conv_bcd;
      end
    end
  end

  // ---------------- display scan ----------------
  logic [RW-1:0] refresh_cnt_q;
  logic [1:0]    idx_q;
  logic [3:0]    digit;
  logic          blank;
  logic [3:0]    scan_onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      idx_q         <= '0;
    end else if (refresh_cnt_q == REF_LAST) begin
      refresh_cnt_q <= '0;
      idx_q         <= idx_q + 2'd1;
    end else begin
      refresh_cnt_q <= refresh_cnt_q + RW'(1);
    end
  end

  // Odd indices are tens digits and get leading-zero blanking.
  always_comb begin
    digit = '0;
    blank = 1'b0;
    case (idx_q)
      2'd0: digit = currBcd[3:0];
      2'd1: begin digit = currBcd[7:4]; blank = (currBcd[7:4] == 4'd0); end
      2'd2: digit = highBcd[3:0];
      2'd3: begin digit = highBcd[7:4]; blank = (highBcd[7:4] == 4'd0); end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) seg <= SEG_0;
    else     seg <= blank ? SEG_BLANK : seg_encode(digit);
  end

  assign scan_onehot = 4'b0001 << idx_q;

`ifdef GAME_OVER_BLINK_EN
  localparam int unsigned   BW        = $clog2(BLINK_DIV + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_q;
  logic          visible_q;

  always_ff @(posedge clk) begin
    if (rst || !isGameComplete) begin
      blink_cnt_q <= '0;
      visible_q   <= 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= '0;
      visible_q   <= ~visible_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BW'(1);
    end
  end

  always_comb an = visible_q ? scan_onehot : 4'b0000;
`else
  logic unused_blink;
  assign unused_blink = isGameComplete ^ BLINK_DIV[0];

  always_comb an = scan_onehot;
`endif

endmodule
